// File: rtl/fb_write_queue_if.sv
// Pixel-write request bus from the memory stage and VRAM write-port bus toward the framebuffer.
// The master modport is the requester/scanout side; the slave modport is the write queue.
interface fb_write_queue_if #(
  parameter int RESOLUTION_X   = 400,
  parameter int RESOLUTION_Y   = 300,
  parameter int PALETTE_LENGTH = 256,
  parameter int DEPTH          = 8
);
  localparam int XW = $clog2(RESOLUTION_X);
  localparam int YW = $clog2(RESOLUTION_Y);
  localparam int VW = $clog2(PALETTE_LENGTH);
  localparam int AW = $clog2(RESOLUTION_X * RESOLUTION_Y);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          fb_wr_en;
  logic [XW-1:0] fb_wr_pxl_x;
  logic [YW-1:0] fb_wr_pxl_y;
  logic [VW-1:0] fb_wr_pxl_value;
  logic          vram_busy;
  logic          fb_full;
  logic [CW-1:0] pending;
  logic          vram_wr_en;
  logic [AW-1:0] vram_wr_addr;
  logic [VW-1:0] vram_wr_data;
  logic [15:0]   dropped_count;

  modport master (
    output fb_wr_en, fb_wr_pxl_x, fb_wr_pxl_y, fb_wr_pxl_value, vram_busy,
    input  fb_full, pending, vram_wr_en, vram_wr_addr, vram_wr_data, dropped_count
  );

  modport slave (
    input  fb_wr_en, fb_wr_pxl_x, fb_wr_pxl_y, fb_wr_pxl_value, vram_busy,
    output fb_full, pending, vram_wr_en, vram_wr_addr, vram_wr_data, dropped_count
  );
endinterface

// File: rtl/fb_write_queue.sv
// Circular write queue between the memory stage and the shared VRAM write port.
// Optional out-of-range filtering and drop counting is enabled by FB_BOUNDS_CHECK_EN.
module fb_write_queue #(
  parameter int RESOLUTION_X   = 400,
  parameter int RESOLUTION_Y   = 300,
  parameter int PALETTE_LENGTH = 256,
  parameter int DEPTH          = 8
) (
  input logic           clk,
  input logic           reset,
  fb_write_queue_if.slave bus
);
  localparam int XW = $clog2(RESOLUTION_X);
  localparam int YW = $clog2(RESOLUTION_Y);
  localparam int VW = $clog2(PALETTE_LENGTH);
  localparam int AW = $clog2(RESOLUTION_X * RESOLUTION_Y);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_mem [DEPTH];
  logic [VW-1:0] data_mem [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [VW-1:0] wr_data_q, wr_data_d;

  logic          full;
  logic          in_range;
  logic          enq;
  logic          deq;
  logic [AW-1:0] enq_addr;

  // Address arithmetic is done at address width, so it wraps exactly like a truncated product.
  assign enq_addr = AW'(bus.fb_wr_pxl_y) * AW'(RESOLUTION_X) + AW'(bus.fb_wr_pxl_x);

  assign full = (count_q == CW'(DEPTH));
  assign enq  = bus.fb_wr_en && !full && in_range;
  assign deq  = (count_q != '0) && !bus.vram_busy;

`ifdef FB_BOUNDS_CHECK_EN
  logic [15:0] dropped_q, dropped_d;

  assign in_range = (32'(bus.fb_wr_pxl_x) < 32'(RESOLUTION_X)) &&
                    (32'(bus.fb_wr_pxl_y) < 32'(RESOLUTION_Y));

  // Out-of-range requests are counted even when the queue is full.
  always_comb begin
    dropped_d = dropped_q;
    if (bus.fb_wr_en && !in_range && (dropped_q != 16'hFFFF)) begin
      dropped_d = dropped_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dropped_q <= '0;
    end else begin
      dropped_q <= dropped_d;
    end
  end

  assign bus.dropped_count = dropped_q;
`else
  assign in_range          = 1'b1;
  assign bus.dropped_count = 16'd0;
`endif

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (enq) begin
      tail_d = tail_q + PW'(1);
    end
    if (deq) begin
      head_d    = head_q + PW'(1);
      wr_en_d   = 1'b1;
      wr_addr_d = addr_mem[head_q];
      wr_data_d = data_mem[head_q];
    end
    count_d = count_q + CW'(enq) - CW'(deq);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[tail_q] <= enq_addr;
      data_mem[tail_q] <= bus.fb_wr_pxl_value;
    end
  end

  assign bus.fb_full      = full;
  assign bus.pending      = count_q;
  assign bus.vram_wr_en   = wr_en_q;
  assign bus.vram_wr_addr = wr_addr_q;
  assign bus.vram_wr_data = wr_data_q;
endmodule

// File: tb/tb_fb_write_queue.sv
// Directed self-checking bench for fb_write_queue with hand-computed expectations.
// Builds with or without FB_BOUNDS_CHECK_EN; the bounds scenario adapts to the build.
module tb_fb_write_queue;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  fb_write_queue_if #(.RESOLUTION_X(400), .RESOLUTION_Y(300),
                      .PALETTE_LENGTH(256), .DEPTH(8)) bus ();

  fb_write_queue #(.RESOLUTION_X(400), .RESOLUTION_Y(300),
                   .PALETTE_LENGTH(256), .DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic en, input int x, input int y, input int v);
    bus.fb_wr_en        = en;
    bus.fb_wr_pxl_x     = 9'(x);
    bus.fb_wr_pxl_y     = 9'(y);
    bus.fb_wr_pxl_value = 8'(v);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    bus.vram_busy = 1'b0;
    set_wr(1'b0, 0, 0, 0);
    tick();
    chk("rst_pending", 32'(bus.pending), 32'd0);
    chk("rst_full", 32'(bus.fb_full), 32'd0);
    chk("rst_wr_en", 32'(bus.vram_wr_en), 32'd0);
    chk("rst_addr", 32'(bus.vram_wr_addr), 32'd0);
    chk("rst_data", 32'(bus.vram_wr_data), 32'd0);
    chk("rst_dropped", 32'(bus.dropped_count), 32'd0);
    reset = 1'b0;
    tick();

    // Single write, minimum latency.
    set_wr(1'b1, 3, 2, 8'h41);
    tick();
    set_wr(1'b0, 0, 0, 0);
    chk("single_pending1", 32'(bus.pending), 32'd1);
    chk("single_en_early", 32'(bus.vram_wr_en), 32'd0);
    tick();
    chk("single_en", 32'(bus.vram_wr_en), 32'd1);
    chk("single_addr", 32'(bus.vram_wr_addr), 32'd803);
    chk("single_data", 32'(bus.vram_wr_data), 32'h41);
    chk("single_pending0", 32'(bus.pending), 32'd0);
    tick();
    chk("single_en_off", 32'(bus.vram_wr_en), 32'd0);
    chk("single_addr_hold", 32'(bus.vram_wr_addr), 32'd803);

    // Fill while busy, write while full, then drain in order.
    bus.vram_busy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_wr(1'b1, i, 1, 8'h10 + i);
      tick();
      chk("fill_en_low", 32'(bus.vram_wr_en), 32'd0);
    end
    chk("fill_full", 32'(bus.fb_full), 32'd1);
    chk("fill_pending", 32'(bus.pending), 32'd8);
    set_wr(1'b1, 9, 1, 8'hFF);
    tick();
    set_wr(1'b0, 0, 0, 0);
    chk("over_pending", 32'(bus.pending), 32'd8);
    bus.vram_busy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("drain_en", 32'(bus.vram_wr_en), 32'd1);
      chk("drain_addr", 32'(bus.vram_wr_addr), 32'(400 + i));
      chk("drain_data", 32'(bus.vram_wr_data), 32'(8'h10 + i));
    end
    tick();
    chk("drain_done_en", 32'(bus.vram_wr_en), 32'd0);
    chk("drain_done_pending", 32'(bus.pending), 32'd0);

    // Busy toggling every cycle: a write follows each low-busy cycle only.
    bus.vram_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_wr(1'b1, 10 + i, 0, 8'h20 + i);
      tick();
    end
    set_wr(1'b0, 0, 0, 0);
    chk("tog_pending", 32'(bus.pending), 32'd4);
    for (int c = 0; c < 8; c++) begin
      bus.vram_busy = c[0];
      tick();
      if (c % 2 == 0) begin
        chk("tog_en_hi", 32'(bus.vram_wr_en), 32'd1);
        chk("tog_addr", 32'(bus.vram_wr_addr), 32'(10 + c / 2));
        chk("tog_data", 32'(bus.vram_wr_data), 32'(8'h20 + c / 2));
      end else begin
        chk("tog_en_lo", 32'(bus.vram_wr_en), 32'd0);
      end
    end
    chk("tog_pending_end", 32'(bus.pending), 32'd0);

    // Full and draining with a new write in the same cycle: write rejected.
    bus.vram_busy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_wr(1'b1, 20 + i, 0, 8'h30 + i);
      tick();
    end
    chk("fd_full", 32'(bus.fb_full), 32'd1);
    bus.vram_busy = 1'b0;
    set_wr(1'b1, 50, 0, 8'h77);
    tick();
    set_wr(1'b0, 0, 0, 0);
    chk("fd_pending", 32'(bus.pending), 32'd7);
    chk("fd_full_off", 32'(bus.fb_full), 32'd0);
    chk("fd_addr0", 32'(bus.vram_wr_addr), 32'd20);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("fd_addr", 32'(bus.vram_wr_addr), 32'(20 + i));
    end
    tick();
    chk("fd_no_extra", 32'(bus.vram_wr_en), 32'd0);
    chk("fd_last_addr", 32'(bus.vram_wr_addr), 32'd27);

    // Reset with 5 entries queued and a strobe in flight.
    bus.vram_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_wr(1'b1, 60 + i, 3, 8'h50 + i);
      tick();
    end
    set_wr(1'b0, 0, 0, 0);
    chk("mr_pending5", 32'(bus.pending), 32'd5);
    bus.vram_busy = 1'b0;
    tick();
    chk("mr_en_hi", 32'(bus.vram_wr_en), 32'd1);
    chk("mr_addr_pre", 32'(bus.vram_wr_addr), 32'd1260);
    #1 reset = 1'b1;
    #1;
    chk("mr_en", 32'(bus.vram_wr_en), 32'd0);
    chk("mr_addr", 32'(bus.vram_wr_addr), 32'd0);
    chk("mr_data", 32'(bus.vram_wr_data), 32'd0);
    chk("mr_pending", 32'(bus.pending), 32'd0);
    chk("mr_full", 32'(bus.fb_full), 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mr_post_en", 32'(bus.vram_wr_en), 32'd0);
    end

    // Out-of-range coordinates.
    set_wr(1'b1, 400, 0, 8'h99);
    tick();
`ifdef FB_BOUNDS_CHECK_EN
    set_wr(1'b1, 0, 300, 8'h9A);
    tick();
    set_wr(1'b0, 0, 0, 0);
    chk("oob_pending", 32'(bus.pending), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("oob_en", 32'(bus.vram_wr_en), 32'd0);
      tick();
    end
    chk("oob_dropped", 32'(bus.dropped_count), 32'd2);
`else
    set_wr(1'b0, 0, 0, 0);
    tick();
    chk("oob_en", 32'(bus.vram_wr_en), 32'd1);
    chk("oob_addr", 32'(bus.vram_wr_addr), 32'd400);
    chk("oob_data", 32'(bus.vram_wr_data), 32'h99);
    chk("oob_dropped", 32'(bus.dropped_count), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
